// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and one-cycle sequencer that gives two requesters access to the shared data memory.
// Each accepted request is checked for legality, is driven onto the memory for one cycle, and gets a registered response.
module dmem_arbiter #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_addr0,
    input  logic [63:0] req_addr1,
    input  logic        req_we0,
    input  logic        req_we1,
    input  logic [63:0] req_wdata0,
    input  logic [63:0] req_wdata1,
    input  logic [3:0]  req_size0,
    input  logic [3:0]  req_size1,
    output logic [1:0]  resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]  r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [3:0]  r_size;
    logic [1:0]  r_resp_valid;
    logic [63:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_winner;
    logic        w_grant;
    logic        w_legal;

    // Bounds sum is 65 bits wide, so an address near 2^64 cannot wrap around into range.
    function automatic logic f_legal(input logic [63:0] addr, input logic [3:0] size);
        logic [64:0] v_end;
        logic        v_size_ok;
        logic        v_align_ok;
        v_size_ok  = (size == 4'd1) || (size == 4'd2) || (size == 4'd4) || (size == 4'd8);
        v_align_ok = (addr[3:0] & (size - 4'd1)) == 4'd0;
        v_end      = {1'b0, addr} + {61'd0, size};
        f_legal    = v_size_ok && v_align_ok && (v_end <= 65'(MEM_BYTES));
    endfunction

    function automatic logic [63:0] f_zext(input logic [63:0] data, input logic [3:0] size);
        case (size)
            4'd1:    f_zext = {56'd0, data[7:0]};
            4'd2:    f_zext = {48'd0, data[15:0]};
            4'd4:    f_zext = {32'd0, data[31:0]};
            4'd8:    f_zext = data;
            default: f_zext = 64'd0;
        endcase
    endfunction

    // When both requesters contend, the one that did not win last time is granted.
    assign w_winner  = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    assign w_grant   = (r_state == S_IDLE) && (|req_valid) && !reset;
    assign req_ready = w_grant ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign w_legal   = f_legal(r_addr, r_size);

    always_comb begin
        mem_address      = 64'd0;
        mem_write_data   = 64'd0;
        mem_xfer_size    = 4'd8;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        if ((r_state == S_ACCESS) && w_legal) begin
            mem_address      = r_addr;
            mem_write_data   = r_wdata;
            mem_xfer_size    = r_size;
            mem_write_enable = r_we && !reset;
            mem_read_enable  = !r_we && !reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_resp_valid <= 2'b00;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 2'b00;
            if (r_state == S_IDLE) begin
                if (w_grant) begin
                    r_state      <= S_ACCESS;
                    r_last_grant <= w_winner;
                end
            end else begin
                r_state      <= S_IDLE;
                r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                r_resp_err   <= ~w_legal;
                r_resp_rdata <= (w_legal && !r_we) ? f_zext(mem_read_data, r_size) : 64'd0;
            end
        end
    end

    // Only the granted requester is sampled, so the other requester's inputs never reach the memory.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_owner <= w_winner;
            r_addr  <= w_winner ? req_addr1  : req_addr0;
            r_we    <= w_winner ? req_we1    : req_we0;
            r_wdata <= w_winner ? req_wdata1 : req_wdata0;
            r_size  <= w_winner ? req_size1  : req_size0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a byte-array memory model, a transaction-level scoreboard, and directed plus random traffic.
module tb_dmem_arbiter;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr0, req_addr1;
    logic        req_we0, req_we1;
    logic [63:0] req_wdata0, req_wdata1;
    logic [3:0]  req_size0, req_size1;
    logic [1:0]  resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_address;
    logic        mem_write_enable, mem_read_enable;
    logic [63:0] mem_write_data;
    logic [3:0]  mem_xfer_size;
    logic [63:0] mem_read_data;

    logic [7:0] env_mem [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_we0(req_we0), .req_we1(req_we1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_size0(req_size0), .req_size1(req_size1),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
        .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    // Memory device: it returns all 8 bytes, so the DUT must zero-extend short reads itself.
    always_comb begin
        mem_read_data = 64'd0;
        for (int i = 0; i < 8; i++)
            if (mem_address + 64'(i) < 64'(MEM_BYTES))
                mem_read_data[i*8 +: 8] = env_mem[mem_address[9:0] + 10'(i)];
    end

    always @(posedge clk) begin
        if (mem_write_enable)
            for (int i = 0; i < int'(mem_xfer_size); i++)
                if (mem_address + 64'(i) < 64'(MEM_BYTES))
                    env_mem[mem_address[9:0] + 10'(i)] <= mem_write_data[i*8 +: 8];
    end

    function automatic bit legal_req(input logic [63:0] a, input logic [3:0] s);
        if (!(s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8)) return 1'b0;
        if ((a % 64'(s)) != 64'd0) return 1'b0;
        if (a > 64'(MEM_BYTES) - 64'(s)) return 1'b0;
        return 1'b1;
    endfunction

    // Scoreboard state: the request in flight, the response owed, and the round-robin history.
    bit          mon_en = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    bit          m_rsp  = 1'b0;
    bit          m_owner, m_we, m_rsp_owner, m_rsp_err;
    logic [63:0] m_addr, m_wdata, m_rsp_data;
    logic [3:0]  m_size;
    int          glog[$];
    int          resp_cnt[2];

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        bit         win;
        bit         lg;
        if (mon_en) begin
            lg = 1'b0;
            if (m_rsp) begin
                check("rsp_valid", resp_valid, m_rsp_owner ? 2'b10 : 2'b01);
                check("rsp_err", resp_err, m_rsp_err);
                check("rsp_rdata", resp_rdata, m_rsp_data);
            end else begin
                check("rsp_quiet", resp_valid, 2'b00);
            end
            if (resp_valid[0]) resp_cnt[0]++;
            if (resp_valid[1]) resp_cnt[1]++;

            win = (req_valid == 2'b11) ? ~m_last : req_valid[1];
            exp_rdy = (reset || m_busy || req_valid == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
            check("ready", req_ready, exp_rdy);
            if (req_ready == 2'b01) glog.push_back(0);
            else if (req_ready == 2'b10) glog.push_back(1);

            if (m_busy) begin
                lg = legal_req(m_addr, m_size);
                check("mem_we", mem_write_enable, !reset && lg && m_we);
                check("mem_re", mem_read_enable, !reset && lg && !m_we);
                if (lg) begin
                    check("mem_addr", mem_address, m_addr);
                    check("mem_size", mem_xfer_size, m_size);
                    if (m_we) check("mem_wdata", mem_write_data, m_wdata);
                end
            end else begin
                check("idle_en", {mem_write_enable, mem_read_enable}, 2'b00);
                check("idle_addr", mem_address, 64'd0);
                check("idle_size", mem_xfer_size, 4'd8);
            end

            if (reset) begin
                m_busy = 1'b0;
                m_last = 1'b1;
                m_rsp  = 1'b0;
            end else if (m_busy) begin
                m_rsp       = 1'b1;
                m_rsp_owner = m_owner;
                m_rsp_err   = !lg;
                m_rsp_data  = 64'd0;
                if (lg && !m_we)
                    for (int i = 0; i < int'(m_size); i++)
                        m_rsp_data[i*8 +: 8] = ref_mem[m_addr[9:0] + 10'(i)];
                if (lg && m_we)
                    for (int i = 0; i < int'(m_size); i++)
                        ref_mem[m_addr[9:0] + 10'(i)] = m_wdata[i*8 +: 8];
                m_busy = 1'b0;
            end else begin
                m_rsp = 1'b0;
                if (exp_rdy != 2'b00) begin
                    m_busy  = 1'b1;
                    m_last  = win;
                    m_owner = win;
                    m_addr  = win ? req_addr1  : req_addr0;
                    m_we    = win ? req_we1    : req_we0;
                    m_wdata = win ? req_wdata1 : req_wdata0;
                    m_size  = win ? req_size1  : req_size0;
                end
            end
        end
    end

    task automatic txn(input bit r, input logic [63:0] a, input bit we, input logic [63:0] wd,
                       input logic [3:0] sz, output logic [63:0] rd, output logic er, output int lat);
        bit found = 1'b0;
        bit got   = 1'b0;
        rd = '1;
        er = 1'b1;
        if (r) begin
            req_addr1 = a; req_we1 = we; req_wdata1 = wd; req_size1 = sz;
            req_addr0 = 'x; req_wdata0 = 'x; req_size0 = 'x; req_we0 = 'x;
        end else begin
            req_addr0 = a; req_we0 = we; req_wdata0 = wd; req_size0 = sz;
            req_addr1 = 'x; req_wdata1 = 'x; req_size1 = 'x; req_we1 = 'x;
        end
        req_valid = r ? 2'b10 : 2'b01;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (req_ready[r]) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("txn_granted", found, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        lat = 1;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (resp_valid[r]) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
            end else begin
                lat++;
                @(posedge clk); #1;
            end
        end
        check("txn_responded", got, 1'b1);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return {$urandom, $urandom};
            1:       return 64'(MEM_BYTES - 8 + int'($urandom_range(0, 8)));
            2:       return 64'($urandom_range(0, MEM_BYTES - 1));
            default: return 64'($urandom_range(0, MEM_BYTES / 8 - 1) * 8);
        endcase
    endfunction

    function automatic logic [3:0] rand_size();
        case ($urandom_range(0, 7))
            0:       return 4'd1;
            1:       return 4'd2;
            2:       return 4'd4;
            3, 4:    return 4'd8;
            5:       return 4'd3;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          found;

        for (int i = 0; i < MEM_BYTES; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        reset = 1'b1;
        req_valid = 2'b00;
        req_addr0 = 0; req_addr1 = 0; req_we0 = 0; req_we1 = 0;
        req_wdata0 = 0; req_wdata1 = 0; req_size0 = 0; req_size1 = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        check("rst_ready", req_ready, 2'b00);
        check("rst_rvalid", resp_valid, 2'b00);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", resp_err, 1'b0);
        check("rst_xsize", mem_xfer_size, 4'd8);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;

        // Write and read back on requester 0; memory bytes 0x10..0x17 become EF CD AB 89 67 45 23 01.
        txn(1'b0, 64'h10, 1'b1, 64'h0123456789ABCDEF, 4'd8, rd, er, lat);
        check("wr_latency", lat, 2);
        check("wr_err", er, 1'b0);
        check("wr_rdata", rd, 64'd0);
        txn(1'b0, 64'h10, 1'b0, 64'd0, 4'd8, rd, er, lat);
        check("rd8_data", rd, 64'h0123456789ABCDEF);
        check("rd8_err", er, 1'b0);
        txn(1'b0, 64'h12, 1'b0, 64'd0, 4'd2, rd, er, lat);
        check("rd2_data", rd, 64'h00000000000089AB);
        txn(1'b0, 64'h13, 1'b0, 64'd0, 4'd1, rd, er, lat);
        check("rd1_data", rd, 64'h0000000000000089);
        txn(1'b1, 64'h14, 1'b0, 64'd0, 4'd4, rd, er, lat);
        check("rd4_r1_data", rd, 64'h0000000001234567);

        txn(1'b0, 64'h3F8, 1'b1, 64'h1122334455667788, 4'd8, rd, er, lat);
        txn(1'b0, 64'h06, 1'b1, '1, 4'd4, rd, er, lat);
        check("misalign_err", er, 1'b1);
        check("misalign_rdata", rd, 64'd0);
        txn(1'b1, 64'h00, 1'b0, '1, 4'd3, rd, er, lat);
        check("size3_err", er, 1'b1);
        check("size3_rdata", rd, 64'd0);
        txn(1'b0, 64'h3FC, 1'b1, '1, 4'd8, rd, er, lat);
        check("oob_err", er, 1'b1);
        check("oob_rdata", rd, 64'd0);
        txn(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, '1, 4'd8, rd, er, lat);
        check("wrap_err", er, 1'b1);
        txn(1'b0, 64'h3F8, 1'b0, 64'd0, 4'd8, rd, er, lat);
        check("edge_intact", rd, 64'h1122334455667788);
        check("edge_err", er, 1'b0);

        // Reset lands on the access cycle of a write, which must neither commit nor respond.
        txn(1'b0, 64'h20, 1'b1, 64'h5A, 4'd1, rd, er, lat);
        req_addr0 = 64'h20; req_we0 = 1'b1; req_wdata0 = 64'hFF; req_size0 = 4'd1;
        req_valid = 2'b01;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (req_ready[0]) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("rstacc_granted", found, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        check("rstacc_we", mem_write_enable, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rstacc_noresp", resp_valid, 2'b00);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Both requesters hold reads for eight grants.
        glog.delete();
        resp_cnt[0] = 0;
        resp_cnt[1] = 0;
        req_addr0 = 64'h40; req_we0 = 1'b0; req_size0 = 4'd8;
        req_addr1 = 64'h80; req_we1 = 1'b0; req_size1 = 4'd4;
        req_valid = 2'b11;
        for (int k = 0; k < 60 && glog.size() < 8; k++) begin
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (4) begin @(posedge clk); #1; end
        check("cont_grants", glog.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < glog.size()) check($sformatf("cont_order%0d", i), glog[i], i % 2);
        check("cont_resp0", resp_cnt[0], 4);
        check("cont_resp1", resp_cnt[1], 4);

        txn(1'b0, 64'h20, 1'b0, 64'd0, 4'd1, rd, er, lat);
        check("rstacc_keep", rd, 64'h5A);

        for (int k = 0; k < 400; k++) begin
            req_valid  = 2'($urandom_range(0, 3));
            req_addr0  = rand_addr();
            req_addr1  = rand_addr();
            req_size0  = rand_size();
            req_size1  = rand_size();
            req_we0    = 1'($urandom);
            req_we1    = 1'($urandom);
            req_wdata0 = {$urandom, $urandom};
            req_wdata1 = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (4) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
